vga_frame_writer: RTL and testbench

//  Write side of the VGA image memory. Accepts a raster-ordered 8-bit pixel stream
//  (RRRGGGBB, e.g. AES-decrypted image bytes) over valid/ready. Writes it into a

---
 rtl/vga_frame_writer_pkg.sv | 20 ++
 rtl/vga_frame_writer_if.sv | 15 +
 rtl/vga_raster_counter.sv | 46 ++++
 rtl/vga_frame_writer.sv | 102 ++++++++++
 tb/tb_vga_frame_writer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_writer_pkg.sv
// Image geometry and writer state encoding. The display reader imports the same
// package so both sides agree on frame size and address layout.
package vga_frame_writer_pkg;

  localparam int unsigned IMG_WIDTH  = 181;
  localparam int unsigned IMG_HEIGHT = 181;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 8;

  localparam int unsigned X_W     = $clog2(IMG_WIDTH);
  localparam int unsigned Y_W     = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned NUM_PIX = IMG_WIDTH * IMG_HEIGHT;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill   = 2'd1,
    StWaitVb = 2'd2
  } wr_state_e;

endpackage

// File: rtl/vga_frame_writer_if.sv
// Raster pixel stream: valid/ready handshake carrying one RRRGGGBB byte per
// transfer, with sof marking the first pixel of a frame.
//   master: drives data, valid, sof; samples ready
//   slave : samples data, valid, sof; drives ready
interface vga_frame_writer_if;
  import vga_frame_writer_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sof;
  logic              ready;

  modport master (output data, output valid, output sof, input ready);
  modport slave  (input data, input valid, input sof, output ready);
endinterface

// File: rtl/vga_raster_counter.sv
// Raster position tracker: x/y coordinates plus a linear row-major address kept
// as an incrementing counter (no multiply).
//   clk, rst : clock, synchronous active-high reset
//   clear    : return to pixel 0
//   advance  : step to the next raster position
//   resync   : the current pixel restarts the frame; next position is (1,0), addr 1
//   x, y     : current column / line
//   addr     : current linear address
//   last     : current position is the final pixel of the frame
module vga_raster_counter
  import vga_frame_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic              resync,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (resync) begin
      x    <= X_W'(1);
      y    <= '0;
      addr <= ADDR_W'(1);
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (x == X_W'(IMG_WIDTH - 1)) begin
        x <= '0;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  assign last = (x == X_W'(IMG_WIDTH - 1)) && (y == Y_W'(IMG_HEIGHT - 1));

endmodule

// File: rtl/vga_frame_writer.sv
// Write side of the double-banked VGA image RAM. Takes a raster-ordered pixel
// stream, writes one frame into the bank the display is not reading, then swaps
// the display bank during vertical blank so the picture never tears.
//   ClkPort, rst : clock, synchronous active-high reset
//   start        : pulse to arm the writer for one frame
//   pix          : pixel stream (slave side)
//   vblank       : display vertical blank
//   wr_en/addr/data/bank : registered RAM write port (one cycle after accept)
//   disp_bank    : bank the display reads
//   busy         : writer not idle
//   frame_done   : pulse on bank swap
//   sync_err     : pulse when sof arrives mid-frame
module vga_frame_writer
  import vga_frame_writer_pkg::*;
(
  input  logic              ClkPort,
  input  logic              rst,
  input  logic              start,
  vga_frame_writer_if.slave pix,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_bank,
  output logic              disp_bank,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err
);

  wr_state_e         state_q;
  logic              accept;
  logic              resync;
  logic              last;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              unused_xy;

  assign pix.ready = (state_q == StFill);
  assign accept    = pix.valid & pix.ready;
  // sof on the first pixel is expected; anywhere else it restarts the frame.
  assign resync    = accept & pix.sof & (addr != '0);
  assign busy      = (state_q != StIdle);
  assign unused_xy = ^{x, y};

  vga_raster_counter u_raster (
    .clk     (ClkPort),
    .rst     (rst),
    .clear   (state_q == StIdle),
    .advance (accept & ~resync),
    .resync  (resync),
    .x       (x),
    .y       (y),
    .addr    (addr),
    .last    (last)
  );

  always_ff @(posedge ClkPort) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b1;
      disp_bank  <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFill;
            wr_bank <= ~disp_bank;
          end
        end
        StFill: begin
          if (accept) begin
            wr_en    <= 1'b1;
            wr_addr  <= resync ? '0 : addr;
            wr_data  <= pix.data;
            sync_err <= resync;
            // A resynced pixel sits at address 0, so it can never be the last.
            if (last && !resync) state_q <= StWaitVb;
          end
        end
        StWaitVb: begin
          if (vblank) begin
            disp_bank  <= wr_bank;
            frame_done <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_writer.sv
module tb_vga_frame_writer;
  import vga_frame_writer_pkg::*;

  localparam int unsigned NPix   = 32761;
  localparam int unsigned SofAt  = 500;
  localparam int unsigned RstAt  = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              vblank;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_bank;
  logic              disp_bank;
  logic              busy;
  logic              frame_done;
  logic              sync_err;

  always #5 clk = ~clk;

  vga_frame_writer_if pix_if ();

  vga_frame_writer dut (
    .ClkPort    (clk),
    .rst        (rst),
    .start      (start),
    .pix        (pix_if),
    .vblank     (vblank),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_bank    (wr_bank),
    .disp_bank  (disp_bank),
    .busy       (busy),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned bank;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_writes = 0;
  int  n_done   = 0;
  int  n_sync   = 0;
  bit  stalled  = 1'b0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Write-port scoreboard: every write must match the next accepted pixel.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", wr_addr, e.addr);
        check_val("wr_data", wr_data, e.data);
        check_val("wr_bank", wr_bank, e.bank);
      end
    end
    if (frame_done) n_done++;
    if (sync_err)   n_sync++;
  end

  // Offer one pixel from a negedge; returns at the negedge after it is taken.
  task automatic send_pix(input logic [7:0] d, input logic sof, input int unsigned ea,
                          input int unsigned eb);
    int  n;
    wr_t e;
    pix_if.valid = 1'b1;
    pix_if.data  = d;
    pix_if.sof   = sof;
    n = 0;
    while (!pix_if.ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (!pix_if.ready) begin
      check_val("ready_timeout", 0, 1);
      stalled = 1'b1;
    end else begin
      e.addr = ea;
      e.data = 32'(d);
      e.bank = eb;
      exp_q.push_back(e);
    end
    @(negedge clk);
    pix_if.valid = 1'b0;
    pix_if.sof   = 1'b0;
  endtask

  task automatic start_frame(input logic exp_bank);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_ready", pix_if.ready, 1);
    check_val("start_wr_bank", wr_bank, exp_bank);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ea;
    int          done_snap;
    rst          = 1'b1;
    start        = 1'b0;
    vblank       = 1'b0;
    pix_if.valid = 1'b0;
    pix_if.data  = '0;
    pix_if.sof   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", pix_if.ready, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_bank", wr_bank, 1);
    check_val("rst_disp_bank", disp_bank, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_sync_err", sync_err, 0);

    // rst and start together: rst wins
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_val("rst_start_busy", busy, 0);

    // Valid while idle is ignored
    pix_if.valid = 1'b1;
    pix_if.data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check_val("idle_ready", pix_if.ready, 0);
    end
    pix_if.valid = 1'b0;

    // Frame A: back-to-back, vblank held high, writes bank 1
    vblank = 1'b1;
    start_frame(1'b1);
    for (int i = 0; i < NPix; i++) begin
      if (stalled) break;
      send_pix(8'(i), i == 0, i, 1);
    end
    check_val("a_done_early", frame_done, 0);
    check_val("a_wait_ready", pix_if.ready, 0);
    @(negedge clk);
    check_val("a_frame_done", frame_done, 1);
    check_val("a_disp_bank", disp_bank, 1);
    check_val("a_busy_after", busy, 0);
    check_val("a_writes", n_writes, NPix);
    check_val("a_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check_val("a_done_pulse", frame_done, 0);

    // Frame B: throttled, mid-frame sof, start ignored, vblank delayed; bank 0
    vblank   = 1'b0;
    n_writes = 0;
    start_frame(1'b0);
    for (int i = 0; i < NPix + SofAt; i++) begin
      if (stalled) break;
      if (i % 16 == 7) @(negedge clk);
      if (i == 100) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("b_start_ignored_busy", busy, 1);
        check_val("b_start_ignored_bank", wr_bank, 0);
      end
      ea = (i < SofAt) ? i : i - SofAt;
      send_pix(8'(ea) ^ 8'h5A, (i == 0) || (i == SofAt), ea, 0);
      if (i == 0)     check_val("b_sof_first_no_err", sync_err, 0);
      if (i == SofAt) check_val("b_sync_err", sync_err, 1);
    end
    repeat (100) begin
      @(negedge clk);
      check_val("b_wait_vb_state", {busy, pix_if.ready, frame_done, disp_bank}, 4'b1001);
    end
    vblank = 1'b1;
    @(negedge clk);
    check_val("b_frame_done", frame_done, 1);
    check_val("b_disp_bank", disp_bank, 0);
    @(negedge clk);
    check_val("b_done_pulse", frame_done, 0);
    check_val("b_busy_after", busy, 0);
    check_val("b_writes", n_writes, NPix + SofAt);
    check_val("b_sync_count", n_sync, 1);
    check_val("b_done_count", n_done, 2);
    check_val("b_queue_empty", exp_q.size(), 0);

    // Frame C: aborted by reset at pixel 1000
    vblank = 1'b0;
    start_frame(1'b1);
    for (int i = 0; i < RstAt; i++) begin
      if (stalled) break;
      send_pix(8'(i), i == 0, i, 1);
    end
    check_val("c_busy_mid", busy, 1);
    done_snap    = n_done;
    rst          = 1'b1;
    pix_if.valid = 1'b1;
    pix_if.data  = 8'h33;
    @(negedge clk);
    rst          = 1'b0;
    pix_if.valid = 1'b0;
    check_val("c_rst_wr_en", wr_en, 0);
    check_val("c_rst_busy", busy, 0);
    check_val("c_rst_ready", pix_if.ready, 0);
    check_val("c_rst_disp_bank", disp_bank, 0);
    check_val("c_rst_wr_bank", wr_bank, 1);
    vblank = 1'b1;
    repeat (5) @(negedge clk);
    check_val("c_no_frame_done", n_done, done_snap);
    check_val("c_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
